// File: rtl/machine_mode_types_1_12_pkg.sv
// rtl/machine_mode_types_1_12_pkg.sv - shared types and interrupt codes for the M-mode trap sequencer
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_EXC,
    KIND_MRET,
    KIND_INT
  } req_kind_e;

  localparam logic [4:0] IRQ_SSI = 5'd1;
  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_STI = 5'd5;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_SEI = 5'd9;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  // Bits of mip/mie that take part in interrupt selection.
  localparam logic [11:0] IRQ_MASK = 12'hAAA;

endpackage

// File: rtl/priv_1_12_int_priority_enc.sv
// rtl/priv_1_12_int_priority_enc.sv - fixed-priority interrupt selector (MEI, MSI, MTI, SEI, SSI, STI)
module priv_1_12_int_priority_enc
  import machine_mode_types_1_12_pkg::*;
(
  input  logic [11:0] int_pending,
  output logic        valid,
  output logic [4:0]  code
);

  logic [11:0] masked;

  assign masked = int_pending & IRQ_MASK;

  always_comb begin
    valid = 1'b1;
    code  = 5'd0;
    if      (masked[11]) code = IRQ_MEI;
    else if (masked[3])  code = IRQ_MSI;
    else if (masked[7])  code = IRQ_MTI;
    else if (masked[9])  code = IRQ_SEI;
    else if (masked[1])  code = IRQ_SSI;
    else if (masked[5])  code = IRQ_STI;
    else                 valid = 1'b0;
  end

endmodule

// File: rtl/priv_1_12_trap_sequencer.sv
// rtl/priv_1_12_trap_sequencer.sv - sequences exception, interrupt and mret entry into CSR strobes and a pc redirect
module priv_1_12_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic [11:0] int_pending,
  input  logic        int_global_en,
  input  logic        mret,
  input  logic [31:0] epc,
  input  logic        pipe_clear,
  input  logic [29:0] mtvec_base,
  input  logic        mtvec_vec,
  input  logic [31:0] curr_mepc,
  output logic        inject_trap,
  output logic        inject_mret,
  output logic [31:0] next_mcause,
  output logic [31:0] next_mepc,
  output logic [31:0] next_mtval,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        busy
);

  trap_state_e state;
  req_kind_e   kind_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic [31:0] mepc_q;

  logic        int_valid;
  logic [4:0]  int_code;
  logic [31:0] vec_base;

  priv_1_12_int_priority_enc u_int_enc (
    .int_pending (int_pending),
    .valid       (int_valid),
    .code        (int_code)
  );

  assign vec_base = {mtvec_base, 2'b00};
  assign busy     = (state != ST_IDLE);

  // Strobes and data are registered so they are valid exactly in the state they belong to.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      kind_q      <= KIND_EXC;
      code_q      <= 5'd0;
      epc_q       <= 32'd0;
      tval_q      <= 32'd0;
      mepc_q      <= 32'd0;
      inject_trap <= 1'b0;
      inject_mret <= 1'b0;
      next_mcause <= 32'd0;
      next_mepc   <= 32'd0;
      next_mtval  <= 32'd0;
      insert_pc   <= 1'b0;
      priv_pc     <= 32'd0;
    end else begin
      inject_trap <= 1'b0;
      inject_mret <= 1'b0;
      next_mcause <= 32'd0;
      next_mepc   <= 32'd0;
      next_mtval  <= 32'd0;
      insert_pc   <= 1'b0;
      priv_pc     <= 32'd0;
      case (state)
        ST_IDLE: begin
          epc_q  <= epc;
          mepc_q <= curr_mepc;
          if (exc_req) begin
            kind_q <= KIND_EXC;
            code_q <= exc_code;
            tval_q <= exc_tval;
            state  <= ST_DRAIN;
          end else if (mret) begin
            kind_q <= KIND_MRET;
            code_q <= 5'd0;
            tval_q <= 32'd0;
            state  <= ST_DRAIN;
          end else if (int_global_en && int_valid) begin
            kind_q <= KIND_INT;
            code_q <= int_code;
            tval_q <= 32'd0;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_clear) begin
            state <= ST_COMMIT;
            if (kind_q == KIND_MRET) begin
              inject_mret <= 1'b1;
            end else begin
              inject_trap <= 1'b1;
              next_mcause <= {kind_q == KIND_INT, 26'd0, code_q};
              next_mepc   <= epc_q;
              next_mtval  <= tval_q;
            end
          end
        end
        ST_COMMIT: begin
          state     <= ST_REDIRECT;
          insert_pc <= 1'b1;
          if (kind_q == KIND_MRET)
            priv_pc <= {mepc_q[31:2], 2'b00};
          else if (kind_q == KIND_INT && mtvec_vec)
            priv_pc <= vec_base + {25'd0, code_q, 2'b00};
          else
            priv_pc <= vec_base;
        end
        ST_REDIRECT: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// tb/tb_priv_1_12_trap_sequencer.sv - directed self-checking bench for the trap sequencer
module tb_priv_1_12_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_tval;
  logic [11:0] int_pending;
  logic        int_global_en;
  logic        mret;
  logic [31:0] epc;
  logic        pipe_clear;
  logic [29:0] mtvec_base;
  logic        mtvec_vec;
  logic [31:0] curr_mepc;
  logic        inject_trap;
  logic        inject_mret;
  logic [31:0] next_mcause;
  logic [31:0] next_mepc;
  logic [31:0] next_mtval;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  priv_1_12_trap_sequencer dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .exc_tval      (exc_tval),
    .int_pending   (int_pending),
    .int_global_en (int_global_en),
    .mret          (mret),
    .epc           (epc),
    .pipe_clear    (pipe_clear),
    .mtvec_base    (mtvec_base),
    .mtvec_vec     (mtvec_vec),
    .curr_mepc     (curr_mepc),
    .inject_trap   (inject_trap),
    .inject_mret   (inject_mret),
    .next_mcause   (next_mcause),
    .next_mepc     (next_mepc),
    .next_mtval    (next_mtval),
    .insert_pc     (insert_pc),
    .priv_pc       (priv_pc),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    exc_req     = 1'b0;
    mret        = 1'b0;
    int_pending = 12'd0;
  endtask

  initial begin
    nRST = 1'b0; exc_req = 1'b0; exc_code = 5'd0; exc_tval = 32'd0;
    int_pending = 12'd0; int_global_en = 1'b0; mret = 1'b0; epc = 32'd0;
    pipe_clear = 1'b1; mtvec_base = 30'h20000000; mtvec_vec = 1'b0; curr_mepc = 32'd0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_trap", {31'd0, inject_trap}, 32'd0);
    chk("rst_ipc", {31'd0, insert_pc}, 32'd0);
    chk("rst_ppc", priv_pc, 32'd0);

    // Exception, minimum latency, accepted on first edge after reset release
    nRST = 1'b1; exc_req = 1'b1; exc_code = 5'd2; exc_tval = 32'hDEADBEEF; epc = 32'h100;
    tick();
    chk("exc_busy", {31'd0, busy}, 32'd1);
    chk("exc_c1_trap", {31'd0, inject_trap}, 32'd0);
    clear_reqs();
    tick();
    chk("exc_trap", {31'd0, inject_trap}, 32'd1);
    chk("exc_mcause", next_mcause, 32'h2);
    chk("exc_mepc", next_mepc, 32'h100);
    chk("exc_mtval", next_mtval, 32'hDEADBEEF);
    chk("exc_c2_ipc", {31'd0, insert_pc}, 32'd0);
    tick();
    chk("exc_ipc", {31'd0, insert_pc}, 32'd1);
    chk("exc_ppc", priv_pc, 32'h80000000);
    chk("exc_c3_trap", {31'd0, inject_trap}, 32'd0);
    chk("exc_c3_mcause", next_mcause, 32'd0);
    tick();
    chk("exc_idle", {31'd0, busy}, 32'd0);
    chk("exc_idle_ppc", priv_pc, 32'd0);

    // Vectored interrupt, bits 7 and 11 -> MEI
    int_pending = 12'h880; int_global_en = 1'b1; mtvec_vec = 1'b1; epc = 32'h200;
    tick();
    clear_reqs();
    tick();
    chk("int_trap", {31'd0, inject_trap}, 32'd1);
    chk("int_mcause", next_mcause, 32'h8000000B);
    chk("int_mepc", next_mepc, 32'h200);
    chk("int_mtval", next_mtval, 32'd0);
    tick();
    chk("int_ppc", priv_pc, 32'h8000002C);
    tick();

    // Vectored target wraps modulo 2^32; SSI beats STI
    mtvec_base = 30'h3FFFFFFF; int_pending = 12'h022;
    tick();
    clear_reqs();
    tick();
    chk("wrap_mcause", next_mcause, 32'h80000001);
    tick();
    chk("wrap_ppc", priv_pc, 32'h00000000);
    tick();
    mtvec_base = 30'h20000000;

    // Exception wins over mret and interrupt
    exc_req = 1'b1; exc_code = 5'd5; exc_tval = 32'h55; mret = 1'b1; int_pending = 12'h008;
    tick();
    clear_reqs();
    tick();
    chk("prio_trap", {31'd0, inject_trap}, 32'd1);
    chk("prio_mret", {31'd0, inject_mret}, 32'd0);
    chk("prio_mcause", next_mcause, 32'h5);
    tick();
    chk("prio_ppc", priv_pc, 32'h80000000);
    tick();

    // Masked interrupt and ignored-only bits are not requests
    int_pending = 12'h800; int_global_en = 1'b0;
    tick(); tick();
    chk("mask_busy", {31'd0, busy}, 32'd0);
    int_pending = 12'h444; int_global_en = 1'b1;
    tick(); tick();
    chk("ign_busy", {31'd0, busy}, 32'd0);
    clear_reqs();

    // mret uses latched mepc, low bits cleared
    mret = 1'b1; curr_mepc = 32'h1003;
    tick();
    clear_reqs(); curr_mepc = 32'hFFFF;
    tick();
    chk("mret_inj", {31'd0, inject_mret}, 32'd1);
    chk("mret_trap", {31'd0, inject_trap}, 32'd0);
    chk("mret_mcause", next_mcause, 32'd0);
    tick();
    chk("mret_ipc", {31'd0, insert_pc}, 32'd1);
    chk("mret_ppc", priv_pc, 32'h1000);
    chk("mret_c3_inj", {31'd0, inject_mret}, 32'd0);
    tick();

    // pipe_clear low for 5 cycles delays COMMIT by exactly 5
    pipe_clear = 1'b0; exc_req = 1'b1; exc_code = 5'd7; epc = 32'h300;
    tick();
    clear_reqs();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_trap_%0d", i), {31'd0, inject_trap}, 32'd0);
      chk($sformatf("stall_busy_%0d", i), {31'd0, busy}, 32'd1);
    end
    pipe_clear = 1'b1;
    tick();
    chk("stall_commit", {31'd0, inject_trap}, 32'd1);
    chk("stall_mcause", next_mcause, 32'h7);
    tick();
    chk("stall_ipc", {31'd0, insert_pc}, 32'd1);
    tick();

    // Reset in DRAIN aborts without strobes
    pipe_clear = 1'b0; exc_req = 1'b1; exc_code = 5'd4;
    tick();
    chk("abort_busy0", {31'd0, busy}, 32'd1);
    clear_reqs(); nRST = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_trap", {31'd0, inject_trap}, 32'd0);
    nRST = 1'b1; pipe_clear = 1'b1;
    tick();
    chk("abort_trap2", {31'd0, inject_trap}, 32'd0);
    chk("abort_busy2", {31'd0, busy}, 32'd0);
    tick();
    chk("abort_ipc", {31'd0, insert_pc}, 32'd0);

    // Back-to-back: held request re-accepted only after returning to IDLE
    exc_req = 1'b1; exc_code = 5'd3;
    tick(); tick(); tick();
    chk("b2b_ipc", {31'd0, insert_pc}, 32'd1);
    tick();
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    clear_reqs();
    tick();
    chk("b2b_trap", {31'd0, inject_trap}, 32'd1);
    chk("b2b_mcause", next_mcause, 32'h3);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
